// File: rtl/common_pkg.sv
// Shared sizes and types for the CLIC interrupt controller slice.
package common_pkg;
    localparam int N_IRQ       = 4;
    localparam int PRIO_W      = 2;
    localparam int STACK_DEPTH = 4;
    localparam int DEPTH_W     = 3;
    localparam int IDX_W       = $clog2(N_IRQ);
    localparam int SP_W        = $clog2(STACK_DEPTH);

    typedef logic [PRIO_W-1:0] Prio;
    typedef logic [IDX_W-1:0]  Index;

    typedef struct packed {
        logic pending;
        Prio  prio;
    } Entry;

    typedef Entry [N_IRQ-1:0] Entries;

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;
endpackage

// File: rtl/can_clic.sv
// Combinational arbiter: highest-priority pending source, lowest index on ties.
module can_clic
    import common_pkg::*;
(
    input  Entries entries,
    output logic   is_interrupt,
    output Index   index
);
    Prio best;

    always_comb begin
        is_interrupt = 1'b0;
        index        = '0;
        best         = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (entries[i].pending && (!is_interrupt || entries[i].prio > best)) begin
                is_interrupt = 1'b1;
                index        = Index'(i);
                best         = entries[i].prio;
            end
        end
    end
endmodule

// File: rtl/clic_prio_stack.sv
// Threshold save stack for nested interrupts; over/underflow latch a sticky err.
module clic_prio_stack
    import common_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  Prio                push_data,
    output Prio                top,
    output logic [DEPTH_W-1:0] depth,
    output logic               err
);
    Prio [STACK_DEPTH-1:0] mem;
    logic [SP_W-1:0]       wr_ptr;
    logic [SP_W-1:0]       rd_ptr;
    logic                  empty;
    logic                  full;

    assign wr_ptr = depth[SP_W-1:0];
    assign rd_ptr = wr_ptr - SP_W'(1);
    assign empty  = (depth == '0);
    assign full   = (depth == DEPTH_W'(STACK_DEPTH));
    assign top    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            depth <= '0;
            err   <= 1'b0;
        end else if (push && pop) begin
            // Popped value goes straight back; only an empty stack has work to do.
            if (empty) begin
                err         <= 1'b1;
                mem[wr_ptr] <= push_data;
                depth       <= depth + DEPTH_W'(1);
            end
        end else if (push) begin
            if (full) begin
                err <= 1'b1;
            end else begin
                mem[wr_ptr] <= push_data;
                depth       <= depth + DEPTH_W'(1);
            end
        end else if (pop) begin
            if (empty) err <= 1'b1;
            else       depth <= depth - DEPTH_W'(1);
        end
    end
endmodule

// File: rtl/clic_irq_ctrl.sv
// CLIC pending/priority entries, request handshake FSM and nesting threshold.
module clic_irq_ctrl
    import common_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_IRQ-1:0]   irq_set,
    input  logic               cfg_we,
    input  Index               cfg_idx,
    input  Prio                cfg_prio,
    output Entries             entries,
    input  logic               is_interrupt,
    input  Index               index,
    output logic               irq_req,
    output Index               irq_id,
    output Prio                irq_level,
    input  logic               irq_ack,
    input  logic               irq_done,
    output Prio                threshold,
    output logic [DEPTH_W-1:0] depth,
    output logic               err
);
    state_e state;
    logic   ack_fire;
    Prio    win_prio;
    Prio    stack_top;

    assign ack_fire = (state == REQ) && irq_ack;
    assign win_prio = entries[index].prio;

    for (genvar i = 0; i < N_IRQ; i++) begin : g_src
        Entry e_q;
        // A fresh set outranks the ack-clear of the same source.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                e_q <= '0;
            end else begin
                if (irq_set[i])                              e_q.pending <= 1'b1;
                else if (ack_fire && irq_id == Index'(i))    e_q.pending <= 1'b0;
                if (cfg_we && cfg_idx == Index'(i))          e_q.prio    <= cfg_prio;
            end
        end
        assign entries[i] = e_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            irq_req   <= 1'b0;
            irq_id    <= '0;
            irq_level <= '0;
        end else begin
            case (state)
                IDLE: if (is_interrupt && win_prio > threshold) begin
                    state     <= REQ;
                    irq_req   <= 1'b1;
                    irq_id    <= index;
                    irq_level <= win_prio;
                end
                REQ: if (irq_ack) begin
                    state   <= IDLE;
                    irq_req <= 1'b0;
                end
            endcase
        end
    end

    // Ack wins over a same-cycle return: the level being entered is the new threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         threshold <= '0;
        else if (ack_fire)                  threshold <= irq_level;
        else if (irq_done && depth != '0)   threshold <= stack_top;
    end

    clic_prio_stack u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ack_fire),
        .pop       (irq_done),
        .push_data (threshold),
        .top       (stack_top),
        .depth     (depth),
        .err       (err)
    );
endmodule
